mem_port_arbiter: RTL

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its memory-stage data port, so the processor can run against a unified memory. It sits between the F/M stages and the memory model and drives per-port stall requests into the hazard logic. Data accesses win by default. A starvation counter guarantees fetch forward progress.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/starve_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  localparam int MIN_STREAK_W = 1;

  // Bits needed to count 0..max_streak inclusive.
  function automatic int streak_width(input int max_streak);
    int w;
    w = $clog2(max_streak + 1);
    return (w < MIN_STREAK_W) ? MIN_STREAK_W : w;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive data grants made while fetch is requesting.
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = streak_width(MAX_DATA_STREAK);
  localparam logic [W-1:0] MAX_CNT = W'(MAX_DATA_STREAK);

  logic [W-1:0] count;

  // Clear wins over increment; the count holds once it reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + W'(1);
    end
  end

  assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch
// port and the data port; data wins unless fetch has been starved too long.
//
//   state     | meaning
//   ARB_IDLE  | no access outstanding, grant may be issued this cycle
//   ARB_FETCH | fetch access in flight, waiting for mem_ack
//   ARB_DATA  | data access in flight, waiting for mem_ack
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t state;

  logic if_elig;
  logic dm_elig;
  logic grant_data;
  logic grant_fetch;
  logic streak_inc;
  logic streak_clr;
  logic at_max;

  assign stall_f = if_req & ~if_done;
  assign stall_m = dm_req & ~dm_done;

  // A port in its done cycle still holds req; mask it so it is not re-granted.
  assign if_elig = if_req & ~if_done;
  assign dm_elig = dm_req & ~dm_done;

  assign grant_data  = (state == ARB_IDLE) & dm_elig & ~(if_elig & at_max);
  assign grant_fetch = (state == ARB_IDLE) & if_elig & ~grant_data;

  assign streak_inc = grant_data & if_req;
  assign streak_clr = grant_fetch | (grant_data & ~if_req);

  starve_counter #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (streak_inc),
    .clr   (streak_clr),
    .at_max(at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_data) begin
            state     <= ARB_DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (grant_fetch) begin
            state    <= ARB_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        ARB_FETCH: begin
          if (mem_ack) begin
            state    <= ARB_IDLE;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end
        end
        ARB_DATA: begin
          if (mem_ack) begin
            state   <= ARB_IDLE;
            mem_req <= 1'b0;
            // Stores leave the last load value visible on dm_rdata.
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_done <= 1'b1;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
